// File: rtl/maze_pkg.sv
// Shared maze definitions: directions, cell geometry, checker FSM states.
// Early exit is selected by MOVE_CHECK_EARLY_EXIT_EN in move_check_seq.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic [9:0] bottom;
        logic [9:0] left;
        logic [9:0] right;
        logic [9:0] top;
    } box_t;

    localparam int CELL_W = 16;
    localparam int CELL_H = 24;

    // Inclusive span [lo,hi] against [s,e]; an inverted span is empty
    function automatic logic span_hit(
        input logic [10:0] lo,
        input logic [10:0] hi,
        input logic [10:0] s,
        input logic [10:0] e
    );
        return (lo <= hi) && (lo <= e) && (hi >= s);
    endfunction

endpackage

// File: rtl/move_check_seq_if.sv
// Move query request/response bundle between sprite motion and checker.
// Carries the query handshake, direction, sprite box and deny result.
interface move_check_seq_if;
    import maze_pkg::*;

    logic       req_valid;
    logic       req_ready;
    dir_t       req_dir;
    logic [9:0] bottom;
    logic [9:0] left;
    logic [9:0] right;
    logic [9:0] top;
    logic       resp_valid;
    logic       resp_ready;
    logic       deny;

    modport master (
        output req_valid, req_dir, bottom, left, right, top, resp_ready,
        input  req_ready, resp_valid, deny
    );

    modport slave (
        input  req_valid, req_dir, bottom, left, right, top, resp_ready,
        output req_ready, resp_valid, deny
    );

endinterface

// File: rtl/wall_row_check.sv
// Combinational wall check of one grid row against the latched sprite box.
// Edge sums are 11 bits wide so right/bottom = 1023 never wrap to 0.
module wall_row_check
    import maze_pkg::*;
#(
    parameter int size_x = 40,
    parameter int row_w  = 5
) (
    input  logic [row_w-1:0]  row,
    input  dir_t              dir,
    input  box_t              box,
    input  logic [0:size_x-1] left_row,
    input  logic [0:size_x-1] top_row,
    output logic              hit
);

    logic [10:0] y0, y1;
    logic [10:0] lo_x, hi_x, lo_y, hi_y;
    logic [10:0] r1, b1;
    logic        row_ov;

    assign y0     = 11'(row) * 11'(CELL_H);
    assign y1     = y0 + 11'(CELL_H - 1);
    assign lo_x   = {1'b0, box.left};
    assign hi_x   = {1'b0, box.right};
    assign lo_y   = {1'b0, box.top};
    assign hi_y   = {1'b0, box.bottom};
    assign r1     = hi_x + 11'd1;
    assign b1     = hi_y + 11'd1;
    assign row_ov = span_hit(lo_y, hi_y, y0, y1);

    always_comb begin
        hit = 1'b0;
        for (int x = 0; x < size_x; x++) begin
            unique case (1'b1)
                dir == LEFT:
                    hit |= left_row[x] && row_ov
                        && lo_x == 11'(x * CELL_W);
                dir == RIGHT:
                    hit |= left_row[x] && row_ov
                        && r1 == 11'(x * CELL_W);
                dir == UP:
                    hit |= top_row[x] && lo_y == y0
                        && span_hit(lo_x, hi_x,
                                    11'(x * CELL_W),
                                    11'(x * CELL_W + CELL_W - 1));
                dir == DOWN:
                    hit |= top_row[x] && b1 == y0
                        && span_hit(lo_x, hi_x,
                                    11'(x * CELL_W),
                                    11'(x * CELL_W + CELL_W - 1));
            endcase
        end
    end

endmodule

// File: rtl/move_check_seq.sv
// Sequential move checker: scans one maze row per clock with a shared checker.
// MOVE_CHECK_EARLY_EXIT_EN ends the scan on the first hitting row.
module move_check_seq
    import maze_pkg::*;
#(
    parameter int size_y = 20,
    parameter int size_x = 40
) (
    input logic                         Clk,
    input logic                         Reset_n,
    move_check_seq_if.slave             bus,
    input logic [size_y-1:0][0:size_x-1] left_constraint,
    input logic [size_y-1:0][0:size_x-1] top_constraint
);

    localparam int ROW_W = (size_y > 1) ? $clog2(size_y) : 1;

    state_t           state;
    logic [ROW_W-1:0] row;
    dir_t             dir_q;
    box_t             box_q;
    logic             hit_q;
    logic             rdy_q, vld_q, dny_q;
    logic             row_hit, last, stop;

    wall_row_check #(
        .size_x(size_x),
        .row_w (ROW_W)
    ) u_row (
        .row     (row),
        .dir     (dir_q),
        .box     (box_q),
        .left_row(left_constraint[row]),
        .top_row (top_constraint[row]),
        .hit     (row_hit)
    );

    assign last = (row == ROW_W'(size_y - 1));

`ifdef MOVE_CHECK_EARLY_EXIT_EN
    assign stop = last || row_hit;
`else
    assign stop = last;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            row   <= '0;
            dir_q <= UP;
            box_q <= '0;
            hit_q <= 1'b0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
            dny_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    dir_q <= bus.req_dir;
                    box_q <= '{bottom: bus.bottom, left: bus.left,
                               right: bus.right, top: bus.top};
                    hit_q <= 1'b0;
                    row   <= '0;
                    rdy_q <= 1'b0;
                    state <= SCAN;
                end
                SCAN: begin
                    hit_q <= hit_q | row_hit;
                    if (stop) begin
                        vld_q <= 1'b1;
                        dny_q <= hit_q | row_hit;
                        state <= DONE;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DONE: if (bus.resp_ready) begin
                    vld_q <= 1'b0;
                    dny_q <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = rdy_q;
    assign bus.resp_valid = vld_q;
    assign bus.deny       = dny_q;

endmodule

// File: tb/tb_move_check_seq.sv
// Scoreboard bench for move_check_seq: directed queries, backpressure, reset.
// Expected latency follows MOVE_CHECK_EARLY_EXIT_EN when defined.
module tb_move_check_seq;
    import maze_pkg::*;

    localparam int SY = 20;
    localparam int SX = 40;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic [SY-1:0][0:SX-1] lc;
    logic [SY-1:0][0:SX-1] tc;

    move_check_seq_if bus();

    move_check_seq #(.size_y(SY), .size_x(SX)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .bus            (bus),
        .left_constraint(lc),
        .top_constraint (tc)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic deny;
        int   due;
    } exp_t;

    exp_t sb[$];
    logic prev_v = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // hit_row = first hitting row, or SY-1 when no row hits
    function automatic int lat(input int hit_row);
`ifdef MOVE_CHECK_EARLY_EXIT_EN
        return hit_row + 2;
`else
        return (hit_row >= 0) ? SY + 1 : SY + 1;
`endif
    endfunction

    always @(negedge Clk) begin
        if (bus.resp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deny", int'(bus.deny), int'(e.deny));
                chk("latency", cyc, e.due);
            end
        end
        prev_v = bus.resp_valid;
    end

    task automatic send(input dir_t d, input int l, input int r,
                        input int t, input int b, input logic exp_deny,
                        input int hit_row, input bit push, output int n);
        int k;
        @(negedge Clk);
        bus.req_dir   = d;
        bus.left      = 10'(l);
        bus.right     = 10'(r);
        bus.top       = 10'(t);
        bus.bottom    = 10'(b);
        bus.req_valid = 1'b1;
        k = 0;
        while (k < 60 && !bus.req_ready) begin
            @(negedge Clk);
            k++;
        end
        n = cyc;
        if (!bus.req_ready) begin
            chk("req_accept_timeout", 0, 1);
        end else if (push) begin
            sb.push_back('{exp_deny, cyc + lat(hit_row)});
        end
        @(negedge Clk);
        bus.req_valid = 1'b0;
        // scramble the box so an unlatched box would change the answer
        bus.left   = 10'd0;
        bus.right  = 10'd1023;
        bus.top    = 10'd0;
        bus.bottom = 10'd1023;
        bus.req_dir = UP;
    endtask

    task automatic finish_resp();
        int k;
        k = 0;
        while (k < 60 && !(bus.resp_valid && bus.resp_ready)) begin
            @(negedge Clk);
            k++;
        end
        if (!(bus.resp_valid && bus.resp_ready))
            chk("resp_timeout", 0, 1);
        @(negedge Clk);
    endtask

    task automatic run(input dir_t d, input int l, input int r,
                       input int t, input int b, input logic exp_deny,
                       input int hit_row);
        int n;
        send(d, l, r, t, b, exp_deny, hit_row, 1'b1, n);
        finish_resp();
    endtask

    initial begin
        int n;
        int k;
        bus.req_valid  = 1'b0;
        bus.req_dir    = UP;
        bus.left       = '0;
        bus.right      = '0;
        bus.top        = '0;
        bus.bottom     = '0;
        bus.resp_ready = 1'b1;
        lc = '0;
        tc = '0;
        repeat (2) @(negedge Clk);
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_deny", int'(bus.deny), 0);
        Reset_n = 1'b1;

        lc = '0; tc = '0; lc[1][2] = 1'b1;
        run(LEFT, 32, 47, 24, 47, 1'b1, 1);
        lc = '0; tc = '0; lc[1][3] = 1'b1;
        run(RIGHT, 32, 47, 24, 47, 1'b1, 1);
        lc = '0; tc = '0; tc[1][2] = 1'b1;
        run(UP, 32, 47, 24, 47, 1'b1, 1);
        run(DOWN, 32, 47, 24, 47, 1'b0, SY - 1);
        lc = '0; tc = '0;
        run(DOWN, 32, 47, 24, 47, 1'b0, SY - 1);
        lc = '0; tc = '0; tc[2][2] = 1'b1;
        run(DOWN, 32, 47, 24, 47, 1'b1, 2);
        lc = '0; tc = '0; lc[1][2] = 1'b1;
        run(LEFT, 32, 47, 47, 24, 1'b0, SY - 1);
        lc = '0; tc = '0; lc[0][0] = 1'b1;
        run(RIGHT, 1008, 1023, 0, 23, 1'b0, SY - 1);
        lc = '0; tc = '0; tc[19][5] = 1'b1;
        run(UP, 80, 95, 456, 479, 1'b1, 19);

        // backpressure on the response
        lc = '0; tc = '0; lc[1][2] = 1'b1;
        bus.resp_ready = 1'b0;
        send(LEFT, 32, 47, 24, 47, 1'b1, 1, 1'b1, n);
        k = 0;
        while (k < 60 && !bus.resp_valid) begin
            @(negedge Clk);
            k++;
        end
        chk("bp_resp_seen", int'(bus.resp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_valid", int'(bus.resp_valid), 1);
            chk("bp_deny", int'(bus.deny), 1);
            chk("bp_req_ready", int'(bus.req_ready), 0);
        end
        bus.resp_ready = 1'b1;
        @(negedge Clk);
        chk("bp_valid_drop", int'(bus.resp_valid), 0);
        chk("bp_req_ready_back", int'(bus.req_ready), 1);

        // reset while row 7 is being scanned
        lc = '0; tc = '0;
        send(LEFT, 32, 47, 24, 47, 1'b0, SY - 1, 1'b0, n);
        while (cyc < n + 8) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", int'(bus.resp_valid), 0);
        chk("mid_rst_req_ready", int'(bus.req_ready), 1);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (25) @(negedge Clk);
        chk("post_rst_idle", int'(bus.req_ready), 1);

        lc = '0; tc = '0; lc[1][2] = 1'b1;
        run(LEFT, 32, 47, 24, 47, 1'b1, 1);

        repeat (3) @(negedge Clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
